// File: rtl/uc_sequencer.sv
// uc_sequencer: fetch/decode control unit for the 16-bit accumulator datapath
module uc_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [15:0]       instr_in,
    input  logic              carry_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              load_r1,
    output logic              load_accu,
    output logic [2:0]        sel_ual,
    output logic              carry_flag,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);
    typedef enum logic [2:0] {FETCH, DECODE, READ, LOADR1, ALU, STORE, JUMP, HALT} state_t;
    state_t state, dec_next;
    logic [ADDR_W-1:0] pc;
    logic [15:0] ir;
    logic flag, live, unused_ir;
    logic [2:0] op, nop;
    assign op = ir[15:13];
    assign nop = instr_in[15:13];
    assign unused_ir = ^ir;
    // Next state chosen from the opcode arriving on the memory bus during DECODE
    always_comb begin
        dec_next = (nop <= 3'd2) ? READ :
                   (nop == 3'd3) ? STORE :
                   (nop[2:1] == 2'b10) ? JUMP :
                   (nop == 3'd6) ? FETCH : HALT;
    end
    // Sequencer state, PC, IR and carry flag; everything holds while run is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            flag  <= 1'b0;
        end else if (run) begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    ir    <= instr_in;
                    pc    <= pc + ADDR_W'(1);
                    state <= dec_next;
                end
                READ:   state <= LOADR1;
                LOADR1: state <= ALU;
                ALU: begin
                    flag  <= (op == 3'd0) ? 1'b0 : carry_in;
                    state <= FETCH;
                end
                STORE:  state <= FETCH;
                JUMP: begin
                    if (op == 3'd5 || !flag) pc <= ir[ADDR_W-1:0];
                    if (op == 3'd4) flag <= 1'b0;
                    state <= FETCH;
                end
                HALT:   state <= HALT;
            endcase
        end
    end
    // Strobes decode from state and are gated off during stall and reset cycles
    always_comb begin
        live       = run && !rst;
        mem_ce     = live && (state == FETCH || state == READ || state == STORE);
        mem_we     = live && state == STORE;
        load_r1    = live && state == LOADR1;
        load_accu  = live && state == ALU;
        mem_addr   = (state == FETCH) ? pc :
                     (state == READ || state == STORE) ? ir[ADDR_W-1:0] : '0;
        sel_ual    = (op == 3'd0) ? 3'b000 : (op == 3'd1) ? 3'b010 : (op == 3'd2) ? 3'b011 : 3'b000;
        carry_flag = flag;
        pc_out     = pc;
        halted     = !rst && state == HALT;
    end
endmodule

// File: tb/tb_uc_sequencer.sv
// tb_uc_sequencer: instruction-level model plus directed programs for uc_sequencer
module tb_uc_sequencer;
    logic clk = 1'b0, rst = 1'b1, run = 1'b1, cmode = 1'b0, cfix = 1'b0;
    logic [15:0] instr_in = '0;
    logic carry_in;
    logic [7:0] mem_addr, pc_out;
    logic mem_ce, mem_we, load_r1, load_accu, carry_flag, halted;
    logic [2:0] sel_ual;
    logic [15:0] mem [256];
    int total = 0, bad = 0;

    uc_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .carry_in(carry_in),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .load_r1(load_r1),
        .load_accu(load_accu), .sel_ual(sel_ual), .carry_flag(carry_flag),
        .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;
    // ALU stand-in: ADD and NOR report carry 1, SUB reports 0, unless a fixed value is chosen
    assign carry_in = cmode ? ~sel_ual[0] : cfix;
    always @(posedge clk) if (mem_ce && !mem_we) instr_in <= mem[mem_addr];

    typedef struct {
        logic ce, we, r1, acc, hlt, flag;
        logic [7:0] addr, pc;
        logic [2:0] sel;
        int upd;
    } rec_t;
    rec_t q[$];
    logic [7:0] m_pc = '0;
    logic [2:0] m_sel = '0;
    logic m_flag = 1'b0, m_halted = 1'b0, chk_en = 1'b0;

    task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(logic ce, we, r1, acc, logic [7:0] addr, int upd);
        rec_t r;
        r.ce = ce; r.we = we; r.r1 = r1; r.acc = acc; r.hlt = 1'b0;
        r.addr = addr; r.pc = m_pc; r.flag = m_flag; r.sel = m_sel; r.upd = upd;
        return r;
    endfunction

    // Expand the next instruction into its expected per-cycle outputs
    task automatic expand();
        logic [15:0] ins;
        logic [2:0] op;
        logic [7:0] a;
        rec_t r;
        if (m_halted) begin
            r = mk(0, 0, 0, 0, 8'h00, 0);
            r.hlt = 1'b1;
            q.push_back(r);
            return;
        end
        ins = mem[m_pc];
        op = ins[15:13];
        a = ins[7:0];
        q.push_back(mk(1, 0, 0, 0, m_pc, 0));
        q.push_back(mk(0, 0, 0, 0, 8'h00, 0));
        m_pc = m_pc + 8'd1;
        m_sel = (op == 3'd0) ? 3'b000 : (op == 3'd1) ? 3'b010 : (op == 3'd2) ? 3'b011 : 3'b000;
        if (op <= 3'd2) begin
            q.push_back(mk(1, 0, 0, 0, a, 0));
            q.push_back(mk(0, 0, 1, 0, 8'h00, 0));
            q.push_back(mk(0, 0, 0, 1, 8'h00, (op == 3'd0) ? 2 : 1));
        end else if (op == 3'd3) begin
            q.push_back(mk(1, 1, 0, 0, a, 0));
        end else if (op == 3'd4 || op == 3'd5) begin
            q.push_back(mk(0, 0, 0, 0, 8'h00, 0));
            if (op == 3'd5 || !m_flag) m_pc = a;
            if (op == 3'd4) m_flag = 1'b0;
        end else if (op == 3'd7) begin
            m_halted = 1'b1;
        end
    endtask

    // Every cycle: compare DUT outputs with the model; a low run stalls the model
    always @(negedge clk) begin
        rec_t r;
        logic st;
        if (rst) begin
            chk("rst_strobes", {mem_ce, mem_we, load_r1, load_accu}, 4'b0000);
            chk("rst_halted", halted, 1'b0);
            q.delete();
            m_pc = '0; m_flag = 1'b0; m_sel = '0; m_halted = 1'b0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            if (q.size() == 0) expand();
            r = q[0];
            st = !run && !r.hlt;
            chk("m_ce", mem_ce, st ? 1'b0 : r.ce);
            chk("m_we", mem_we, st ? 1'b0 : r.we);
            chk("m_r1", load_r1, st ? 1'b0 : r.r1);
            chk("m_acc", load_accu, st ? 1'b0 : r.acc);
            chk("m_addr", mem_addr, r.addr);
            chk("m_pc", pc_out, r.pc);
            chk("m_sel", sel_ual, r.sel);
            chk("m_flag", carry_flag, r.flag);
            chk("m_halted", halted, r.hlt);
            if (!st) begin
                void'(q.pop_front());
                if (r.upd == 1) m_flag = carry_in;
                else if (r.upd == 2) m_flag = 1'b0;
            end
        end
    end

    task automatic go(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic mid();
        @(negedge clk);
    endtask
    task automatic fill();
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    endtask
    task automatic release_rst();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // ADD with carry, then JCC not taken, then JCC taken, then HLT
        fill();
        mem[0] = 16'h2010; mem[1] = 16'h8020; mem[2] = 16'h8020; mem[8'h10] = 16'h1234;
        cfix = 1'b1;
        release_rst();
        mid(); chk("c1_addr", mem_addr, 8'h00); chk("c1_ce", mem_ce, 1'b1);
        go(2); mid(); chk("c3_addr", mem_addr, 8'h10); chk("c3_ce", mem_ce, 1'b1);
        go(1); mid(); chk("c4_r1", load_r1, 1'b1);
        go(1); mid(); chk("c5_acc", load_accu, 1'b1); chk("c5_sel", sel_ual, 3'b010); chk("c5_pc", pc_out, 8'h01);
        go(1); mid(); chk("c6_addr", mem_addr, 8'h01); chk("c6_flag", carry_flag, 1'b1);
        go(3); mid(); chk("jcc_nt_addr", mem_addr, 8'h02); chk("jcc_nt_pc", pc_out, 8'h02); chk("jcc_nt_flag", carry_flag, 1'b0);
        go(3); mid(); chk("jcc_t_addr", mem_addr, 8'h20); chk("jcc_t_pc", pc_out, 8'h20);
        go(2); mid(); chk("hlt", halted, 1'b1);
        for (int i = 0; i < 20; i++) begin run = ~run; go(1); end
        run = 1'b1;
        mid(); chk("hlt_hold", halted, 1'b1); chk("hlt_ce", mem_ce, 1'b0);
        go(1); rst = 1'b1;
        mid(); chk("hlt_rst_halted", halted, 1'b0);
        release_rst();
        mid(); chk("hlt_rel_addr", mem_addr, 8'h00); chk("hlt_rel_ce", mem_ce, 1'b1); chk("hlt_rel_halted", halted, 1'b0);
        // Flag rules: ADD carry 1, SUB carry 0, ADD carry 1, NOR carry 1
        go(1); rst = 1'b1;
        fill();
        mem[0] = 16'h2010; mem[1] = 16'h4010; mem[2] = 16'h2010; mem[3] = 16'h0010;
        cmode = 1'b1;
        release_rst();
        go(5); mid(); chk("add_flag", carry_flag, 1'b1);
        go(4); mid(); chk("sub_sel", sel_ual, 3'b011);
        go(1); mid(); chk("sub_flag", carry_flag, 1'b0);
        go(5); mid(); chk("add2_flag", carry_flag, 1'b1);
        go(4); mid(); chk("nor_sel", sel_ual, 3'b000); chk("nor_acc", load_accu, 1'b1);
        go(1); mid(); chk("nor_flag", carry_flag, 1'b0);
        go(4);
        cmode = 1'b0; rst = 1'b1;
        // STA: single write cycle
        fill(); mem[0] = 16'h603F;
        release_rst();
        go(1); mid(); chk("sta_c2_we", mem_we, 1'b0);
        go(1); mid(); chk("sta_we", {mem_ce, mem_we}, 2'b11); chk("sta_addr", mem_addr, 8'h3F); chk("sta_ld", {load_r1, load_accu}, 2'b00);
        go(1); mid(); chk("sta_next_we", mem_we, 1'b0); chk("sta_next_addr", mem_addr, 8'h01); chk("sta_next_ce", mem_ce, 1'b1);
        go(1); rst = 1'b1;
        // Stall three cycles in READ
        fill(); mem[0] = 16'h2010; cfix = 1'b0;
        release_rst();
        go(2); run = 1'b0;
        mid(); chk("stall_ce", mem_ce, 1'b0); chk("stall_addr", mem_addr, 8'h10);
        go(2); mid(); chk("stall3_ce", mem_ce, 1'b0); chk("stall3_addr", mem_addr, 8'h10);
        go(1); run = 1'b1;
        mid(); chk("resume_ce", mem_ce, 1'b1); chk("resume_addr", mem_addr, 8'h10);
        go(1); mid(); chk("resume_r1", load_r1, 1'b1);
        go(1); mid(); chk("resume_acc", load_accu, 1'b1);
        go(1); rst = 1'b1;
        // JMP to 0xFF, NOP there, PC wraps to 0
        fill(); mem[0] = 16'hA0FF; mem[8'hFF] = 16'hC000;
        release_rst();
        go(3); mid(); chk("jmp_addr", mem_addr, 8'hFF); chk("jmp_pc", pc_out, 8'hFF);
        go(2); mid(); chk("wrap_addr", mem_addr, 8'h00); chk("wrap_pc", pc_out, 8'h00); chk("wrap_ce", mem_ce, 1'b1);
        go(6); rst = 1'b1;
        // Reset during the ALU cycle of an ADD with carry 1
        fill(); mem[0] = 16'h2010; cfix = 1'b1;
        release_rst();
        go(4); rst = 1'b1;
        mid(); chk("alu_rst_acc", load_accu, 1'b0); chk("alu_rst_halted", halted, 1'b0);
        go(1); rst = 1'b0;
        mid(); chk("alu_rst_addr", mem_addr, 8'h00); chk("alu_rst_ce", mem_ce, 1'b1); chk("alu_rst_flag", carry_flag, 1'b0);
        go(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
